pkt_repeat: RTL

- Inverse of the packet averager on the channel-sounder path.
- Captures one input packet of pkt_size samples into a dual-port RAM, then replays it rep_size times as back-to-back AXI-Stream packets, each terminated by o_tlast.
- Sits on the TX side to regenerate a repeated sounding sequence from a single loaded template.

---
 rtl/pkt_rpt_pkg.sv | 13 +
 rtl/pkt_rpt_skid.sv | 54 +++++
 rtl/ram_2port.sv | 30 +++
 rtl/pkt_repeat.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/pkt_rpt_pkg.sv
// rtl/pkt_rpt_pkg.sv - shared state encodings and reset-time config for pkt_repeat
package pkt_rpt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_PLAY = 2'd2
    } state_t;

    localparam int DEF_PKT_SIZE = 32;
    localparam int DEF_REP_SIZE = 32;

endpackage

// File: rtl/pkt_rpt_skid.sv
// rtl/pkt_rpt_skid.sv - two-entry output buffer carrying sample plus tlast
module pkt_rpt_skid #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_tdata,
    input  logic             i_tlast,
    input  logic             i_tvalid,
    output logic [WIDTH-1:0] o_tdata,
    output logic             o_tlast,
    output logic             o_tvalid,
    input  logic             i_tready,
    output logic [1:0]       o_count
);

    logic [WIDTH:0] r_mem [2];
    logic           r_wr_idx;
    logic           r_rd_idx;
    logic [1:0]     r_count;
    logic           w_push;
    logic           w_pop;
    logic           w_head_last;

    assign w_push = i_tvalid;
    assign w_pop  = (r_count != 2'd0) && i_tready;

    // The writer throttles itself on o_count, so a push never meets a full buffer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_idx <= 1'b0;
            r_rd_idx <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_idx] <= {i_tlast, i_tdata};
                r_wr_idx        <= ~r_wr_idx;
            end
            if (w_pop) begin
                r_rd_idx <= ~r_rd_idx;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign {w_head_last, o_tdata} = r_mem[r_rd_idx];
    assign o_tvalid = (r_count != 2'd0);
    assign o_tlast  = w_head_last && o_tvalid;
    assign o_count  = r_count;

endmodule

// File: rtl/ram_2port.sv
// rtl/ram_2port.sv - simple dual-port RAM, one write port, one registered read port
module ram_2port #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 14
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AWIDTH-1:0] i_waddr,
    input  logic [DWIDTH-1:0] i_wdata,
    input  logic              i_re,
    input  logic [AWIDTH-1:0] i_raddr,
    output logic [DWIDTH-1:0] o_rdata
);

    logic [DWIDTH-1:0] r_mem [2**AWIDTH];
    logic [DWIDTH-1:0] r_rdata;

    // Contents deliberately have no reset; every FILL rewrites the used range.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pkt_repeat.sv
// rtl/pkt_repeat.sv - captures one packet into RAM and replays it rep_size times
module pkt_repeat #(
    parameter int MAX_PKT_SIZE_LOG2 = 14,
    parameter int MAX_REP_SIZE_LOG2 = 10,
    parameter int WIDTH             = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             i_tdata,
    input  logic                         i_tlast,
    input  logic                         i_tvalid,
    output logic                         i_tready,
    output logic [WIDTH-1:0]             o_tdata,
    output logic                         o_tlast,
    output logic                         o_tvalid,
    input  logic                         o_tready,
    input  logic [MAX_PKT_SIZE_LOG2-1:0] i_pkt_size,
    input  logic [MAX_REP_SIZE_LOG2-1:0] i_rep_size
);

    import pkt_rpt_pkg::*;

    localparam logic [MAX_PKT_SIZE_LOG2-1:0] PKT_ONE = MAX_PKT_SIZE_LOG2'(1);
    localparam logic [MAX_REP_SIZE_LOG2-1:0] REP_ONE = MAX_REP_SIZE_LOG2'(1);

    state_t                         r_state;
    state_t                         w_state_next;
    logic [MAX_PKT_SIZE_LOG2-1:0]   r_pkt_size;
    logic [MAX_REP_SIZE_LOG2-1:0]   r_rep_size;
    logic [MAX_PKT_SIZE_LOG2-1:0]   r_wr_ptr;
    logic [MAX_PKT_SIZE_LOG2-1:0]   r_rd_ptr;
    logic [MAX_REP_SIZE_LOG2-1:0]   r_copy_cnt;
    logic                           r_done;
    logic                           r_rd_valid;
    logic                           r_rd_last;

    logic [MAX_PKT_SIZE_LOG2-1:0]   w_pkt_last;
    logic [MAX_REP_SIZE_LOG2-1:0]   w_rep_last;
    logic                           w_bypass;
    logic                           w_byp_active;
    logic                           w_in_ready;
    logic                           w_wr_en;
    logic                           w_issue;
    logic [WIDTH-1:0]               w_rdata;
    logic [WIDTH-1:0]               w_skid_tdata;
    logic                           w_skid_tlast;
    logic                           w_skid_tvalid;
    logic [1:0]                     w_skid_count;
    logic                           w_pop;
    logic [2:0]                     w_proj;

    assign w_pkt_last   = r_pkt_size - PKT_ONE;
    assign w_rep_last   = r_rep_size - REP_ONE;
    assign w_bypass     = (r_pkt_size == '0) || (r_rep_size < MAX_REP_SIZE_LOG2'(2));
    assign w_byp_active = (r_state == ST_IDLE) && w_bypass;
    assign w_pop        = w_skid_tvalid && o_tready;

    // Skid occupancy after this cycle's pop plus the read already in flight.
    assign w_proj = {1'b0, w_skid_count} - {2'b00, w_pop} + {2'b00, r_rd_valid};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_wr_en      = 1'b0;
        w_issue      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_bypass && i_tvalid) begin
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                w_in_ready = 1'b1;
                w_wr_en    = i_tvalid;
                if (i_tvalid && (r_wr_ptr == w_pkt_last)) begin
                    w_state_next = ST_PLAY;
                end
            end
            ST_PLAY: begin
                w_issue = !r_done && (w_proj < 3'd2);
                if (r_done && !r_rd_valid && (w_skid_count == 2'd1) && w_pop) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pkt_size <= MAX_PKT_SIZE_LOG2'(DEF_PKT_SIZE);
            r_rep_size <= MAX_REP_SIZE_LOG2'(DEF_REP_SIZE);
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_copy_cnt <= '0;
            r_done     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
        end else begin
            r_rd_valid <= w_issue;
            if (w_issue) begin
                r_rd_last <= (r_rd_ptr == w_pkt_last);
            end
            case (r_state)
                ST_IDLE: begin
                    r_pkt_size <= i_pkt_size;
                    r_rep_size <= i_rep_size;
                    r_wr_ptr   <= '0;
                    r_rd_ptr   <= '0;
                    r_copy_cnt <= '0;
                    r_done     <= 1'b0;
                end
                ST_FILL: begin
                    if (w_wr_en) begin
                        r_wr_ptr <= (r_wr_ptr == w_pkt_last) ? '0 : r_wr_ptr + PKT_ONE;
                    end
                end
                ST_PLAY: begin
                    if (w_issue) begin
                        if (r_rd_ptr == w_pkt_last) begin
                            r_rd_ptr <= '0;
                            if (r_copy_cnt == w_rep_last) begin
                                r_done <= 1'b1;
                            end else begin
                                r_copy_cnt <= r_copy_cnt + REP_ONE;
                            end
                        end else begin
                            r_rd_ptr <= r_rd_ptr + PKT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    ram_2port #(
        .DWIDTH (WIDTH),
        .AWIDTH (MAX_PKT_SIZE_LOG2)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_tdata),
        .i_re    (w_issue),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    pkt_rpt_skid #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk      (clk),
        .reset    (reset),
        .i_tdata  (w_rdata),
        .i_tlast  (r_rd_last),
        .i_tvalid (r_rd_valid),
        .o_tdata  (w_skid_tdata),
        .o_tlast  (w_skid_tlast),
        .o_tvalid (w_skid_tvalid),
        .i_tready (o_tready),
        .o_count  (w_skid_count)
    );

    assign i_tready = w_byp_active ? o_tready : w_in_ready;
    assign o_tdata  = w_byp_active ? i_tdata  : w_skid_tdata;
    assign o_tlast  = w_byp_active ? i_tlast  : w_skid_tlast;
    assign o_tvalid = w_byp_active ? i_tvalid : w_skid_tvalid;

endmodule
